// File: rtl/alu_pkg.sv
// Shared constants for the ALU result path: word widths, grant, state and
// priority-mode encodings, plus the arbitration decision helper.
package alu_pkg;

    localparam int ALU_DATA_SIZE      = 16;
    localparam int ALU_ID_SIZE        = 8;
    localparam int ALU_FIFO_OUT_WIDTH = ALU_DATA_SIZE + 1 + ALU_ID_SIZE;
    localparam int ALU_CNT_WIDTH      = 8;

    localparam logic GNT_ADD = 1'b0;
    localparam logic GNT_MUL = 1'b1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    localparam logic PRIO_RR        = 1'b0;
    localparam logic PRIO_MUL_FIRST = 1'b1;

    // A lone requester always wins; on a tie the mode decides, and round-robin
    // hands the slot to whichever source did not win last time.
    function automatic logic pick_winner(
        input logic a_valid,
        input logic m_valid,
        input logic prio_mode,
        input logic last_grant
    );
        logic win;
        if (a_valid && m_valid) begin
            if (prio_mode == PRIO_RR) begin
                win = (last_grant == GNT_ADD) ? GNT_MUL : GNT_ADD;
            end else begin
                win = GNT_MUL;
            end
        end else if (m_valid) begin
            win = GNT_MUL;
        end else begin
            win = GNT_ADD;
        end
        return win;
    endfunction

endpackage

// File: rtl/alu_result_arbiter_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter
    import alu_pkg::*;
#(
    parameter int CNT_WIDTH = ALU_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_r;

    // Count register: clear beats increment, increment stops at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/alu_result_arbiter.sv
// Arbitrates adder and multiplier results onto the single result FIFO write
// port, acknowledging the winner and counting completions per source.
module alu_result_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_SIZE      = ALU_DATA_SIZE,
    parameter int ID_SIZE        = ALU_ID_SIZE,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + 1 + ID_SIZE,
    parameter int CNT_WIDTH      = ALU_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid_res,
    input  logic [FIFO_OUT_WIDTH-1:0] result_add,
    input  logic                      m_valid_res,
    input  logic [FIFO_OUT_WIDTH-1:0] result_mul,
    input  logic                      ready_f_res,
    input  logic                      prio_mode,
    input  logic                      cnt_clr,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_res,
    output logic                      sum_written,
    output logic                      mul_written,
    output logic [CNT_WIDTH-1:0]      add_cnt,
    output logic [CNT_WIDTH-1:0]      mul_cnt,
    output logic                      busy
);

    logic                      state_r;
    logic                      last_grant_r;
    logic                      w_en_r;
    logic [FIFO_OUT_WIDTH-1:0] fifo_res_r;
    logic                      sum_written_r;
    logic                      mul_written_r;
    logic                      busy_r;

    logic start_s;
    logic win_s;

    // Grant decision, only meaningful in IDLE with FIFO space and a requester
    always_comb begin
        start_s = 1'b0;
        win_s   = last_grant_r;
        if ((state_r == ST_IDLE) && ready_f_res && (a_valid_res || m_valid_res)) begin
            start_s = 1'b1;
            win_s   = pick_winner(a_valid_res, m_valid_res, prio_mode, last_grant_r);
        end else begin
            start_s = 1'b0;
            win_s   = last_grant_r;
        end
    end

    // Two-state FSM; every write-side output is registered so WRITE drives them directly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GNT_MUL;
            w_en_r        <= 1'b0;
            fifo_res_r    <= {FIFO_OUT_WIDTH{1'b0}};
            sum_written_r <= 1'b0;
            mul_written_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r       <= ST_WRITE;
                        last_grant_r  <= win_s;
                        w_en_r        <= 1'b1;
                        fifo_res_r    <= (win_s == GNT_MUL) ? result_mul : result_add;
                        sum_written_r <= (win_s == GNT_ADD);
                        mul_written_r <= (win_s == GNT_MUL);
                        busy_r        <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        last_grant_r  <= last_grant_r;
                        w_en_r        <= 1'b0;
                        fifo_res_r    <= fifo_res_r;
                        sum_written_r <= 1'b0;
                        mul_written_r <= 1'b0;
                        busy_r        <= 1'b0;
                    end
                end
                // Valids are not sampled here, so a source still asserting
                // valid during its ack cannot be granted twice.
                ST_WRITE: begin
                    state_r       <= ST_IDLE;
                    last_grant_r  <= last_grant_r;
                    w_en_r        <= 1'b0;
                    fifo_res_r    <= fifo_res_r;
                    sum_written_r <= 1'b0;
                    mul_written_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    last_grant_r  <= last_grant_r;
                    w_en_r        <= 1'b0;
                    fifo_res_r    <= fifo_res_r;
                    sum_written_r <= 1'b0;
                    mul_written_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_add_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sum_written_r),
        .clr   (cnt_clr),
        .count (add_cnt)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mul_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mul_written_r),
        .clr   (cnt_clr),
        .count (mul_cnt)
    );

    assign w_en_out    = w_en_r;
    assign fifo_res    = fifo_res_r;
    assign sum_written = sum_written_r;
    assign mul_written = mul_written_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_alu_result_arbiter.sv
// Directed bench for alu_result_arbiter: reset, latency, both arbitration
// modes, FIFO-full stall and counter saturation/clear.
module tb_alu_result_arbiter;

    localparam int W  = 25;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          a_valid_res;
    logic [W-1:0]  result_add;
    logic          m_valid_res;
    logic [W-1:0]  result_mul;
    logic          ready_f_res;
    logic          prio_mode;
    logic          cnt_clr;
    logic          w_en_out;
    logic [W-1:0]  fifo_res;
    logic          sum_written;
    logic          mul_written;
    logic [CW-1:0] add_cnt;
    logic [CW-1:0] mul_cnt;
    logic          busy;

    int err_cnt;
    int chk_cnt;

    logic   grant_log[$];
    logic [W-1:0] word_log[$];
    int     wcyc_log[$];

    alu_result_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid_res (a_valid_res),
        .result_add  (result_add),
        .m_valid_res (m_valid_res),
        .result_mul  (result_mul),
        .ready_f_res (ready_f_res),
        .prio_mode   (prio_mode),
        .cnt_clr     (cnt_clr),
        .w_en_out    (w_en_out),
        .fifo_res    (fifo_res),
        .sum_written (sum_written),
        .mul_written (mul_written),
        .add_cnt     (add_cnt),
        .mul_cnt     (mul_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        a_valid_res = 1'b0;
        m_valid_res = 1'b0;
        cnt_clr     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Each source holds valid while it has requests left and retires one per ack
    task automatic run_traffic(input int n_add, input int n_mul, input int budget);
        int rem_a;
        int rem_m;
        int cyc;
        rem_a = n_add;
        rem_m = n_mul;
        cyc   = 0;
        grant_log.delete();
        word_log.delete();
        wcyc_log.delete();
        a_valid_res = (rem_a > 0);
        m_valid_res = (rem_m > 0);
        while (((rem_a > 0) || (rem_m > 0)) && (cyc < budget)) begin
            step();
            cyc++;
            if (w_en_out) begin
                grant_log.push_back(mul_written);
                word_log.push_back(fifo_res);
                wcyc_log.push_back(cyc);
            end
            if (sum_written) begin
                rem_a--;
                if (rem_a == 0) a_valid_res = 1'b0;
            end
            if (mul_written) begin
                rem_m--;
                if (rem_m == 0) m_valid_res = 1'b0;
            end
        end
        a_valid_res = 1'b0;
        m_valid_res = 1'b0;
        check_val("traffic_timeout", rem_a + rem_m, 0);
        step();
    endtask

    initial begin
        int stall_hits;
        logic exp_g;
        err_cnt     = 0;
        chk_cnt     = 0;
        result_add  = 25'h0AB1234;
        result_mul  = 25'h1C05678;
        ready_f_res = 1'b1;
        prio_mode   = 1'b0;
        apply_reset();

        check_val("rst_wen",  w_en_out, 0);
        check_val("rst_res",  fifo_res, 0);
        check_val("rst_sack", sum_written, 0);
        check_val("rst_mack", mul_written, 0);
        check_val("rst_acnt", add_cnt, 0);
        check_val("rst_mcnt", mul_cnt, 0);
        check_val("rst_busy", busy, 0);

        // Reset landing in the WRITE cycle
        a_valid_res = 1'b1;
        step();
        check_val("rw_wen_pre", w_en_out, 1);
        rst         = 1'b1;
        a_valid_res = 1'b0;
        step();
        check_val("rw_wen",  w_en_out, 0);
        check_val("rw_sack", sum_written, 0);
        check_val("rw_mack", mul_written, 0);
        check_val("rw_busy", busy, 0);
        check_val("rw_acnt", add_cnt, 0);
        rst = 1'b0;
        step();

        // Adder alone: one-cycle latency, then fifo_res holds
        a_valid_res = 1'b1;
        step();
        check_val("add_wen",  w_en_out, 1);
        check_val("add_res",  fifo_res, 25'h0AB1234);
        check_val("add_sack", sum_written, 1);
        check_val("add_mack", mul_written, 0);
        check_val("add_busy", busy, 1);
        a_valid_res = 1'b0;
        step();
        check_val("add_wen_off", w_en_out, 0);
        check_val("add_cnt1",    add_cnt, 1);
        check_val("add_hold",    fifo_res, 25'h0AB1234);
        check_val("add_busy_off", busy, 0);

        // Round-robin: after reset last_grant is MUL, so ADD goes first
        apply_reset();
        prio_mode = 1'b0;
        run_traffic(4, 4, 40);
        check_val("rr_nwrites", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) begin
            exp_g = (i % 2 == 1);
            check_val($sformatf("rr_grant%0d", i), grant_log[i], exp_g);
            check_val($sformatf("rr_word%0d", i), word_log[i], exp_g ? 25'h1C05678 : 25'h0AB1234);
            check_val($sformatf("rr_cyc%0d", i), wcyc_log[i], 2 * i + 1);
        end
        check_val("rr_acnt", add_cnt, 4);
        check_val("rr_mcnt", mul_cnt, 4);

        // Fixed priority: MUL drains before ADD is served
        prio_mode = 1'b1;
        run_traffic(1, 2, 40);
        check_val("fx_nwrites", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check_val("fx_grant0", grant_log[0], 1);
            check_val("fx_grant1", grant_log[1], 1);
            check_val("fx_grant2", grant_log[2], 0);
        end
        check_val("fx_acnt", add_cnt, 5);
        check_val("fx_mcnt", mul_cnt, 6);
        prio_mode = 1'b0;

        // FIFO full stalls the request in IDLE
        ready_f_res = 1'b0;
        a_valid_res = 1'b1;
        stall_hits  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (w_en_out || sum_written || mul_written) stall_hits++;
        end
        check_val("full_nowrite", stall_hits, 0);
        ready_f_res = 1'b1;
        step();
        check_val("full_wen",  w_en_out, 1);
        check_val("full_sack", sum_written, 1);
        a_valid_res = 1'b0;
        step();
        check_val("full_acnt", add_cnt, 6);

        // Saturation after 300 adder writes, then clear coincident with a write
        apply_reset();
        run_traffic(300, 0, 700);
        check_val("sat_nwrites", grant_log.size(), 300);
        check_val("sat_acnt",    add_cnt, 255);
        check_val("sat_mcnt",    mul_cnt, 0);
        a_valid_res = 1'b1;
        step();
        check_val("clr_wen", w_en_out, 1);
        cnt_clr     = 1'b1;
        a_valid_res = 1'b0;
        step();
        cnt_clr = 1'b0;
        check_val("clr_acnt", add_cnt, 0);
        a_valid_res = 1'b1;
        step();
        a_valid_res = 1'b0;
        step();
        check_val("clr_recount", add_cnt, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_result_arbiter.md
Name: alu_result_arbiter

Overview:
Shares the single result FIFO write port between the adder and multiplier result channels. Arbitrates with round-robin or fixed multiplier-first priority and registers the winning result into the output FIFO. Pulses a per-source written acknowledge and keeps saturating per-source completion counters for the CSR status path. Sits between adder/mul_fsm and the result fifo_synch, replacing out_alu_control_unit.

Parameters:
DATA_SIZE, 16, operand/result data width
ID_SIZE, 8, transaction ID width
FIFO_OUT_WIDTH, DATA_SIZE+1+ID_SIZE (25), result word width, passed through unmodified
CNT_WIDTH, 8, width of each completion counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
a_valid_res  in  1  adder result valid; held until sum_written is seen
result_add  in  FIFO_OUT_WIDTH  adder result word
m_valid_res  in  1  multiplier result valid; held until mul_written is seen
result_mul  in  FIFO_OUT_WIDTH  multiplier result word
ready_f_res  in  1  result FIFO not full (!full_out)
prio_mode  in  1  0 = round-robin, 1 = fixed multiplier-first
cnt_clr  in  1  synchronous clear of both counters
w_en_out  out  1  result FIFO write enable
fifo_res  out  FIFO_OUT_WIDTH  result FIFO write data
sum_written  out  1  one-cycle ack to adder
mul_written  out  1  one-cycle ack to multiplier
add_cnt  out  CNT_WIDTH  saturating count of adder results written
mul_cnt  out  CNT_WIDTH  saturating count of multiplier results written
busy  out  1  high while in WRITE state

Behaviour:
- Reset values: w_en_out=0, fifo_res=0, sum_written=0, mul_written=0, add_cnt=0, mul_cnt=0, busy=0; state=IDLE; last_grant=MUL, so the first round-robin tie goes to ADD. Reset mid-WRITE aborts the write: no w_en_out or ack in the following cycle.
- FSM states: IDLE and WRITE.
- IDLE → WRITE when ready_f_res=1 and (a_valid_res or m_valid_res).
  - On this edge: grant is latched, fifo_res <= the winner's result word, and last_grant <= winner.
  - IDLE holds while ready_f_res=0, whatever the valids are.
- WRITE (exactly 1 cycle): w_en_out=1, busy=1, and the winner's *_written=1. Always returns to IDLE next.
  - The loser's valid is ignored during WRITE.
  - The winner drops its valid in the cycle after its ack. The arbiter never samples valids in WRITE, so there is no double grant.
- Latency: valid rising in IDLE with space gives w_en_out and ack on the next cycle. Peak throughput is 1 write per 2 cycles.
- Arbitration when both are valid:
  - prio_mode=1: MUL wins.
  - prio_mode=0: the source not equal to last_grant wins.
  - Single valid: that source wins regardless of mode.
  - A prio_mode change takes effect at the next IDLE decision.
- Full handling: ready_f_res is checked only at the IDLE decision. The FIFO has a single writer, so space checked at IDLE is guaranteed in WRITE (reads only free space). ready_f_res falling during WRITE does not cancel the write.
- fifo_res holds its last value when not writing. Result word bits pass through unchanged: {id, carry/overflow, data}.
- Counters:
  - Increment on the WRITE cycle for the granted source.
  - Saturate at 2^CNT_WIDTH-1.
  - cnt_clr has priority: a clear coincident with an increment yields 0.

Decomposition:
- Package alu_pkg: FIFO_OUT_WIDTH derivation, grant encoding (GNT_ADD=0, GNT_MUL=1), FSM state encoding (IDLE, WRITE), prio_mode encodings.
- Sub-module sat_counter (CNT_WIDTH, inc, clr, rst): instantiated twice for add_cnt and mul_cnt.
- The arbiter FSM stays in the top.

Test Plan:
- Reset during WRITE (rst=1 in the cycle after the grant decision) → next cycle: w_en_out=0, both acks 0, counters 0.
- Adder only, result_add=25'h0AB1234, ready_f_res=1 → exactly 1 cycle later: w_en_out=1, fifo_res=25'h0AB1234, sum_written=1, mul_written=0; add_cnt=1.
- Both valid continuously, prio_mode=0, acks honoured, 4 requests each → w_en_out every 2nd cycle, grant order ADD, MUL, ADD, MUL…; add_cnt=mul_cnt=4.
- Both valid, prio_mode=1 → MUL granted first; ADD is granted only after m_valid_res drops.
- ready_f_res=0 for 10 cycles with a_valid_res=1 → no w_en_out and no ack; once ready_f_res=1, the write occurs 1 cycle later.
- 300 adder writes with CNT_WIDTH=8 → add_cnt saturates at 255. cnt_clr pulsed in the same cycle as a write → add_cnt=0.
